// File: rtl/apb_master.sv
// APB requester: accepts one upstream request at a time and runs it as a single APB transfer.
// Optional ACCESS-phase timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master #(
    parameter int TO_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [3:0]  req_strb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    input  logic        pready
);

    // state  | meaning
    // IDLE   | ready for a new upstream request
    // SETUP  | APB setup phase, psel=1 penable=0, one cycle
    // ACCESS | APB access phase, waiting for pready (or timeout)
    // RESP   | response held on rsp_* until rsp_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;
    logic   accept;
    logic   done;
    logic   abort;

    assign done = (state == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
    localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    // Completion has priority: abort only fires when pready is low.
    assign abort = (state == ACCESS) && !pready && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !pready && !abort) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;

    if (TO_CYCLES > 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rstn;
                accept    = req_valid && rstn;
                if (accept) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                psel     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done || abort) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // APB request fields are captured once at accept and held until the next accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pstrb     <= '0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= {req_addr[31:2], 2'b00};
                pwrite <= req_write;
                pstrb  <= req_write ? req_strb : 4'b0000;
                pwdata <= req_wdata;
            end
            if (done) begin
                rsp_rdata <= pwrite ? 32'h0 : prdata;
                rsp_err   <= pslverr;
            end else if (abort) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized bench for apb_master with a transaction-level reference model.
// Build with APB_TIMEOUT_EN defined to cover the timeout abort (TO_CYCLES=4 here).
module tb_apb_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pready;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(.TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_strb  (req_strb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pstrb     (pstrb),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_apb(input string ph, input logic [31:0] a, input logic w,
                           input logic [3:0] s, input logic [31:0] wd);
        chk32({ph, "_paddr"}, paddr, a);
        chk1({ph, "_pwrite"}, pwrite, w);
        chk32({ph, "_pstrb"}, {28'h0, pstrb}, {28'h0, s});
        chk32({ph, "_pwdata"}, pwdata, wd);
        chk1({ph, "_req_ready"}, req_ready, 1'b0);
        chk1({ph, "_rsp_valid"}, rsp_valid, 1'b0);
    endtask

    function automatic logic rbit();
        return $urandom_range(0, 1) != 0;
    endfunction

    // One transfer, called at a negedge with the DUT idle; returns at the negedge after the
    // response handshake. waits = ACCESS cycles with pready=0 before the completer answers.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, input int waits, input logic err_in,
                        input logic [31:0] rd, input int rdly, input bit keep);
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          abort;
        int          n_acc;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_strb = w ? s : 4'h0;
`ifdef APB_TIMEOUT_EN
        abort = (waits >= TO);
`else
        abort = 1'b0;
`endif
        n_acc   = abort ? TO : waits + 1;
        exp_err = abort ? 1'b1 : err_in;
        exp_rd  = (abort || w) ? 32'h0 : rd;

        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_psel", psel, 1'b0);
        chk1("idle_rsp_valid", rsp_valid, 1'b0);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_strb  = s;
        req_wdata = wd;
        pready    = rbit();
        pslverr   = rbit();
        @(negedge clk);
        chk1("setup_psel", psel, 1'b1);
        chk1("setup_penable", penable, 1'b0);
        chk_apb("setup", exp_addr, w, exp_strb, wd);
        if (!keep) req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = rbit();
        req_strb  = 4'($urandom_range(0, 15));
        pready    = rbit();
        pslverr   = rbit();
        prdata    = $urandom;
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            chk1("access_psel", psel, 1'b1);
            chk1("access_penable", penable, 1'b1);
            chk_apb("access", exp_addr, w, exp_strb, wd);
            pready  = (i == waits);
            pslverr = (i == waits) ? err_in : rbit();
            prdata  = (i == waits) ? rd : $urandom;
        end
        for (int j = 0; j <= rdly; j++) begin
            @(negedge clk);
            chk1("resp_valid", rsp_valid, 1'b1);
            chk32("resp_rdata", rsp_rdata, exp_rd);
            chk1("resp_err", rsp_err, exp_err);
            chk1("resp_psel", psel, 1'b0);
            chk1("resp_penable", penable, 1'b0);
            chk1("resp_req_ready", req_ready, 1'b0);
            rsp_ready = (j == rdly);
            pready    = rbit();
            pslverr   = rbit();
            prdata    = $urandom;
        end
        @(negedge clk);
        chk1("post_rsp_valid", rsp_valid, 1'b0);
        chk1("post_psel", psel, 1'b0);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string ph);
        chk1({ph, "_psel"}, psel, 1'b0);
        chk1({ph, "_penable"}, penable, 1'b0);
        chk1({ph, "_pwrite"}, pwrite, 1'b0);
        chk32({ph, "_paddr"}, paddr, 32'h0);
        chk32({ph, "_pstrb"}, {28'h0, pstrb}, 32'h0);
        chk32({ph, "_pwdata"}, pwdata, 32'h0);
        chk1({ph, "_rsp_valid"}, rsp_valid, 1'b0);
        chk32({ph, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk1({ph, "_rsp_err"}, rsp_err, 1'b0);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_write = 1'b0;
        req_strb  = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        prdata    = 32'h0;
        pslverr   = 1'b0;
        pready    = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        chk1("reset_release_req_ready", req_ready, 1'b1);

        // Read, zero wait states, immediate consume.
        xfer(32'h0200_BFF8, 1'b0, 4'hF, 32'hAAAA_5555, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
        // Unaligned write, 3 wait states.
        xfer(32'h0C00_2003, 1'b1, 4'h3, 32'hDEAD_BEEF, 3, 1'b0, 32'h7777_7777, 0, 1'b0);
        // Write with slave error, response held off for 4 cycles.
        xfer(32'h0000_1004, 1'b1, 4'hC, 32'h0BAD_F00D, 1, 1'b1, 32'h0, 4, 1'b0);
        // Back-to-back with req_valid held high throughout.
        xfer(32'h1000_0010, 1'b0, 4'h0, 32'h0, 2, 1'b0, 32'hCAFE_0001, 1, 1'b1);
        xfer(32'h1000_0014, 1'b1, 4'h5, 32'h1111_2222, 0, 1'b0, 32'h0, 0, 1'b0);
        // Stuck completer (aborts when the timeout is built), then pready on the 4th ACCESS cycle.
        xfer(32'h2000_0000, 1'b0, 4'h0, 32'h0, 9, 1'b0, 32'h5A5A_5A5A, 1, 1'b0);
        xfer(32'h2000_0040, 1'b0, 4'h0, 32'h0, TO - 1, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);

        // Reset during ACCESS abandons the transfer.
        chk1("rst_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = 32'h3000_0008;
        req_write = 1'b1;
        req_strb  = 4'hF;
        req_wdata = 32'h3333_4444;
        @(negedge clk);
        req_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        chk1("rst_access_penable", penable, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pready  = rbit();
            pslverr = rbit();
            @(negedge clk);
            chk1("after_rst_rsp_valid", rsp_valid, 1'b0);
            chk1("after_rst_psel", psel, 1'b0);
            chk1("after_rst_req_ready", req_ready, 1'b1);
        end
        xfer(32'h3000_000C, 1'b0, 4'h0, 32'h0, 1, 1'b0, 32'h0F0F_F0F0, 0, 1'b0);

        // Randomized transfers with idle gaps.
        for (int t = 0; t < 30; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                pready  = rbit();
                pslverr = rbit();
                @(negedge clk);
                chk1("gap_req_ready", req_ready, 1'b1);
                chk1("gap_psel", psel, 1'b0);
                chk1("gap_rsp_valid", rsp_valid, 1'b0);
            end
            xfer($urandom, rbit(), 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 5), rbit(), $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
            req_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 256, meaning ACCESS-phase cycles before timeout abort; used only when APB_TIMEOUT_EN is defined.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rstn  input  1  synchronous active-low reset.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_strb  input  4  write byte lanes.
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  upstream consumes response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and aborted transfers.
REQ-014 rsp_err  output  1  slave error or timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  32;  pstrb  output  4;  pwdata  output  32  APB address, strobes and write data.
REQ-017 prdata  input  32;  pslverr  input  1;  pready  input  1  APB completer response.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, addr/write/strb/wdata SHALL be registered and the FSM SHALL enter SETUP.
REQ-020 SETUP SHALL last exactly one cycle with psel=1, penable=0, then enter ACCESS.
REQ-021 ACCESS SHALL drive psel=1, penable=1 and stay until pready=1.
REQ-022 paddr SHALL be {addr[31:2],2'b00}; pwrite = registered write; pwdata = registered wdata; pstrb = registered strb for writes, 4'b0000 for reads.
REQ-023 paddr, pwrite, pstrb and pwdata SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-024 In the ACCESS cycle with pready=1, rsp_rdata SHALL capture prdata for reads (0 for writes) and rsp_err SHALL capture pslverr; the FSM SHALL enter RESP.
REQ-025 RESP SHALL drive rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then return to IDLE.
REQ-026 psel and penable SHALL be 0 in IDLE and RESP.
REQ-027 Minimum latency: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 if pready=1 at N+2.
REQ-028 Only one transfer SHALL be outstanding; no new request is accepted before the response handshake completes, including the RESP cycle with rsp_ready=1.
REQ-029 pready and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-030 When rstn=0 at a clock edge, the FSM SHALL go to IDLE and psel, penable, pwrite, paddr, pstrb, pwdata, rsp_valid, rsp_rdata, rsp_err and the timeout counter SHALL be 0; req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abandon the transfer without a response.

Configuration
REQ-032 Macro APB_TIMEOUT_EN: when defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle with pready=0; when the count reaches TO_CYCLES-1 with pready=0, the transfer SHALL abort to RESP with rsp_err=1 and rsp_rdata=0, and psel/penable SHALL drop the next cycle.
REQ-033 If pready=1 in the same cycle the count reaches TO_CYCLES-1, the completion SHALL win: normal response, no abort.
REQ-034 When APB_TIMEOUT_EN is undefined, ACCESS SHALL wait indefinitely, and the counter and parameter SHALL have no hardware effect.

Verification
REQ-035 Read at 0x0200_BFF8, pready=1 at the first ACCESS cycle, prdata=0x1234_5678 -> rsp_valid at N+3, rsp_rdata=0x1234_5678, rsp_err=0, pstrb=0 throughout.
REQ-036 Write at 0x0C00_2003, strb=0x3, wdata=0xDEAD_BEEF, 3 wait states -> paddr=0x0C00_2000, signals stable for 5 APB cycles, rsp_err=0, rsp_rdata=0.
REQ-037 Write with pslverr=1 at the pready cycle -> rsp_err=1; rsp_ready held low 4 cycles -> rsp_valid stays asserted and req_ready stays 0.
REQ-038 Back-to-back req_valid held high for two requests -> second accepted only in the cycle after the first response handshake.
REQ-039 APB_TIMEOUT_EN defined, TO_CYCLES=4, pready stuck at 0 -> abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0; repeated with pready=1 on the 4th ACCESS cycle -> normal completion.
REQ-040 rstn=0 during ACCESS -> all outputs 0 the next cycle, no rsp_valid, and the next request proceeds normally.
